dac_seg_sequencer: RTL and testbench

DAC_SEG_SEQUENCER -- requirements
Module: dac_seg_sequencer

---
 rtl/dac_ctrl_pkg.sv | 31 +++
 rtl/dac_therm_dem.sv | 47 ++++
 rtl/dac_seg_sequencer.sv | 154 +++++++++++++++
 tb/tb_dac_seg_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ctrl_pkg.sv
// Shared constants, FSM state encoding and helpers for the segmented DAC controller.
// Binary LSB width, thermometer cell count and the zero-code levels live here.
package dac_ctrl_pkg;

    localparam int NBIN   = 7;
    localparam int NTHERM = 17;
    localparam int KW     = 5;   // width of the thermometer count field code[11:7]
    localparam int PTRW   = 5;   // holds 0..NTHERM-1
    localparam int CODEW  = NBIN + KW;

    localparam logic [NBIN-1:0]   ZERO_BIN   = '0;
    localparam logic [NTHERM-1:0] ZERO_THERM = '0;
    localparam logic [NBIN-1:0]   SAT_BIN    = '1;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_PWRUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_PWRDN = 3'd3,
        ST_FAULT = 3'd4
    } dac_state_e;

    function automatic logic is_over(input logic [KW-1:0] raw);
        return raw > KW'(NTHERM);
    endfunction

    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] raw);
        return is_over(raw) ? KW'(NTHERM) : raw;
    endfunction

endpackage

// File: rtl/dac_therm_dem.sv
// Count-to-thermometer encoder with rotating start pointer for dynamic element matching.
// o_therm is combinational from the current pointer; the pointer advances by k on each load.
module dac_therm_dem
    import dac_ctrl_pkg::*;
#(
    parameter bit DEM_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [KW-1:0]     i_k,
    output logic [NTHERM-1:0] o_therm
);

    logic [PTRW-1:0]     r_ptr;
    logic [NTHERM-1:0]   w_base;
    logic [2*NTHERM-1:0] w_dbl;
    logic [PTRW:0]       w_sum;
    logic [PTRW:0]       w_wrap;

    always_comb begin
        w_base = '0;
        for (int i = 0; i < NTHERM; i++) begin
            w_base[i] = (i < int'(i_k));
        end
    end

    // Rotate left by r_ptr: bits shifted past the top fold back into bit 0 upward.
    assign w_dbl   = {{NTHERM{1'b0}}, w_base} << r_ptr;
    assign o_therm = w_dbl[NTHERM-1:0] | w_dbl[2*NTHERM-1:NTHERM];

    assign w_sum  = {1'b0, r_ptr} + {1'b0, i_k};
    assign w_wrap = w_sum - (PTRW+1)'(NTHERM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_clr || !DEM_EN) begin
            r_ptr <= '0;
        end else if (i_load) begin
            // ptr + k never exceeds 2*NTHERM-1, so one conditional subtract is a full mod.
            r_ptr <= (w_sum >= (PTRW+1)'(NTHERM)) ? w_wrap[PTRW-1:0] : w_sum[PTRW-1:0];
        end
    end

endmodule

// File: rtl/dac_seg_sequencer.sv
// Power sequencing and sample path for a 7-bit binary + 17-cell thermometer DAC driver.
// Sequences OFF/PWRUP/RUN/PWRDN/FAULT and registers the segmented control words.
module dac_seg_sequencer
    import dac_ctrl_pkg::*;
#(
    parameter int PU_CYCLES = 16,
    parameter int PD_CYCLES = 4,
    parameter bit DEM_EN    = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_supply_ok,
    input  logic [CODEW-1:0]  i_code,
    input  logic              i_code_valid,
    output logic              o_code_ready,
    output logic              o_pdb,
    output logic [NBIN-1:0]   o_datain,
    output logic [NBIN-1:0]   o_datainb,
    output logic [NTHERM-1:0] o_datatherm,
    output logic [NTHERM-1:0] o_datathermb,
    output logic              o_sat,
    output logic              o_fault
);

    localparam int CNT_MAX = (PU_CYCLES > PD_CYCLES) ? PU_CYCLES : PD_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    dac_state_e          r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_pdb;
    logic [NBIN-1:0]     r_datain;
    logic [NTHERM-1:0]   r_therm;
    logic                r_sat;
    logic                r_fault;

    logic [KW-1:0]       w_k_raw;
    logic [KW-1:0]       w_k;
    logic                w_over;
    logic                w_xfer;
    logic                w_to_off;
    logic                w_pu_done;
    logic                w_pd_done;
    logic [NTHERM-1:0]   w_therm;

    assign w_k_raw   = i_code[CODEW-1:NBIN];
    assign w_over    = is_over(w_k_raw);
    assign w_k       = clamp_k(w_k_raw);
    assign w_pu_done = (r_cnt == CW'(PU_CYCLES - 1));
    assign w_pd_done = (r_cnt == CW'(PD_CYCLES - 1));

    // Ready is gated by the live inputs so a dropping supply or enable wins over a
    // pending handshake on the same edge.
    assign o_code_ready = (r_state == ST_RUN) && i_en && i_supply_ok;
    assign w_xfer       = i_code_valid && o_code_ready;

    assign w_to_off = i_supply_ok &&
                      (((r_state == ST_PWRDN) && w_pd_done) ||
                       ((r_state == ST_FAULT) && !i_en));

    dac_therm_dem #(
        .DEM_EN (DEM_EN)
    ) u_dem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_xfer),
        .i_clr   (w_to_off),
        .i_k     (w_k),
        .o_therm (w_therm)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_OFF;
            r_cnt    <= '0;
            r_pdb    <= 1'b0;
            r_datain <= ZERO_BIN;
            r_therm  <= ZERO_THERM;
            r_sat    <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_sat <= 1'b0;
            if ((r_state != ST_OFF) && !i_supply_ok) begin
                r_state  <= ST_FAULT;
                r_pdb    <= 1'b0;
                r_datain <= ZERO_BIN;
                r_therm  <= ZERO_THERM;
                r_fault  <= 1'b1;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        if (i_en && i_supply_ok) begin
                            r_state <= ST_PWRUP;
                            r_pdb   <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PWRUP: begin
                        if (!i_en) begin
                            r_state <= ST_PWRDN;
                            r_cnt   <= '0;
                        end else if (w_pu_done) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!i_en) begin
                            r_state  <= ST_PWRDN;
                            r_cnt    <= '0;
                            r_datain <= ZERO_BIN;
                            r_therm  <= ZERO_THERM;
                        end else if (w_xfer) begin
                            r_datain <= w_over ? SAT_BIN : i_code[NBIN-1:0];
                            r_therm  <= w_therm;
                            r_sat    <= w_over;
                        end
                    end
                    ST_PWRDN: begin
                        if (w_pd_done) begin
                            r_state <= ST_OFF;
                            r_pdb   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        if (!i_en) begin
                            r_state <= ST_OFF;
                            r_fault <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_OFF;
                        r_pdb    <= 1'b0;
                        r_datain <= ZERO_BIN;
                        r_therm  <= ZERO_THERM;
                        r_fault  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_pdb        = r_pdb;
    assign o_datain     = r_datain;
    assign o_datainb    = ~r_datain;
    assign o_datatherm  = r_therm;
    assign o_datathermb = ~r_therm;
    assign o_sat        = r_sat;
    assign o_fault      = r_fault;

endmodule

// File: tb/tb_dac_seg_sequencer.sv
// Directed and randomized checks of dac_seg_sequencer against a cycle-level reference model.
module tb_dac_seg_sequencer;

    localparam int PU = 16;
    localparam int PD = 4;
    localparam bit DEM = 1'b1;

    localparam int M_OFF = 0, M_PWRUP = 1, M_RUN = 2, M_PWRDN = 3, M_FAULT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        supply_ok = 1'b1;
    logic [11:0] code = '0;
    logic        code_valid = 1'b0;
    logic        code_ready, pdb, sat, fault;
    logic [6:0]  datain, datainb;
    logic [16:0] datatherm, datathermb;

    int n_tests = 0;
    int n_fail  = 0;

    dac_seg_sequencer #(.PU_CYCLES(PU), .PD_CYCLES(PD), .DEM_EN(DEM)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_supply_ok  (supply_ok),
        .i_code       (code),
        .i_code_valid (code_valid),
        .o_code_ready (code_ready),
        .o_pdb        (pdb),
        .o_datain     (datain),
        .o_datainb    (datainb),
        .o_datatherm  (datatherm),
        .o_datathermb (datathermb),
        .o_sat        (sat),
        .o_fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] therm_of(input int p, input int k);
        logic [16:0] t;
        t = '0;
        for (int i = 0; i < k; i++) t[(p + i) % 17] = 1'b1;
        return t;
    endfunction

    // Reference model: phase plus cycles spent in it, DEM pointer and expected outputs.
    int          m_mode = M_OFF;
    int          m_t = 0;
    int          m_ptr = 0;
    logic        m_pdb = 1'b0;
    logic [6:0]  m_din = '0;
    logic [16:0] m_therm = '0;
    logic        m_sat = 1'b0;
    logic        m_fault = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int mk;
        if (!rst_n) begin
            m_mode <= M_OFF; m_t <= 0; m_ptr <= 0; m_pdb <= 1'b0;
            m_din <= '0; m_therm <= '0; m_sat <= 1'b0; m_fault <= 1'b0;
        end else begin
            m_sat <= 1'b0;
            if (m_mode != M_OFF && !supply_ok) begin
                m_mode <= M_FAULT; m_pdb <= 1'b0; m_din <= '0; m_therm <= '0; m_fault <= 1'b1;
            end else if (m_mode == M_OFF) begin
                if (en && supply_ok) begin m_mode <= M_PWRUP; m_pdb <= 1'b1; m_t <= 0; end
            end else if (m_mode == M_PWRUP) begin
                if (!en) begin m_mode <= M_PWRDN; m_t <= 0; end
                else begin
                    m_t <= m_t + 1;
                    if (m_t + 1 == PU) m_mode <= M_RUN;
                end
            end else if (m_mode == M_RUN) begin
                if (!en) begin
                    m_mode <= M_PWRDN; m_t <= 0; m_din <= '0; m_therm <= '0;
                end else if (code_valid) begin
                    mk = int'(code[11:7]);
                    if (mk > 17) begin mk = 17; m_din <= 7'h7F; m_sat <= 1'b1; end
                    else m_din <= code[6:0];
                    m_therm <= therm_of(m_ptr, mk);
                    m_ptr <= DEM ? (m_ptr + mk) % 17 : 0;
                end
            end else if (m_mode == M_PWRDN) begin
                m_t <= m_t + 1;
                if (m_t + 1 == PD) begin m_mode <= M_OFF; m_pdb <= 1'b0; m_ptr <= 0; end
            end else begin
                if (!en) begin m_mode <= M_OFF; m_fault <= 1'b0; m_ptr <= 0; end
            end
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (rst_n) begin
            chk("pdb", {31'b0, pdb}, {31'b0, m_pdb});
            chk("datain", {25'b0, datain}, {25'b0, m_din});
            chk("datatherm", {15'b0, datatherm}, {15'b0, m_therm});
            chk("sat", {31'b0, sat}, {31'b0, m_sat});
            chk("fault", {31'b0, fault}, {31'b0, m_fault});
            chk("code_ready", {31'b0, code_ready},
                {31'b0, (m_mode == M_RUN) && en && supply_ok});
            chk("datainb_inv", {25'b0, datainb ^ datain}, 32'h7F);
            chk("datathermb_inv", {15'b0, datathermb ^ datatherm}, 32'h1FFFF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!code_ready && n < 40) begin tick(); n++; end
        chk(nm, n, PU);
    endtask

    task automatic send(input logic [11:0] c);
        code = c; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_pdb", {31'b0, pdb}, 0);
        chk("rst_datainb", {25'b0, datainb}, 32'h7F);
        chk("rst_thermb", {15'b0, datathermb}, 32'h1FFFF);
        chk("rst_ready", {31'b0, code_ready}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Power-up: pdb one edge after en, ready exactly PU edges later
        en = 1'b1;
        tick();
        chk("pu_pdb", {31'b0, pdb}, 1);
        chk("pu_ready0", {31'b0, code_ready}, 0);
        wait_ready("pu_cycles");

        // Saturation with ptr=0
        send(12'hFFF);
        chk("sat_therm", {15'b0, datatherm}, 32'h1FFFF);
        chk("sat_din", {25'b0, datain}, 32'h7F);
        chk("sat_pulse", {31'b0, sat}, 1);
        tick();
        chk("sat_clear", {31'b0, sat}, 0);
        chk("sat_hold", {15'b0, datatherm}, 32'h1FFFF);

        // DEM wrap: move ptr to 15, then k=3 wraps
        send(12'h780);
        chk("dem_k15", {15'b0, datatherm}, 32'h07FFF);
        send(12'h180);
        chk("dem_wrap", {15'b0, datatherm}, 32'h18001);
        send(12'h080);
        chk("dem_ptr1", {15'b0, datatherm}, 32'h00002);

        // Fault beats a pending handshake
        code = 12'h123; code_valid = 1'b1; supply_ok = 1'b0;
        #1;
        chk("flt_ready", {31'b0, code_ready}, 0);
        tick();
        chk("flt_pdb", {31'b0, pdb}, 0);
        chk("flt_fault", {31'b0, fault}, 1);
        chk("flt_therm", {15'b0, datatherm}, 0);
        chk("flt_din", {25'b0, datain}, 0);
        code_valid = 1'b0; supply_ok = 1'b1; en = 1'b0;
        tick();
        chk("flt_exit", {31'b0, fault}, 0);

        // Power-down: PD cycles of zero code with pdb held, then off
        en = 1'b1;
        tick();
        wait_ready("pu2_cycles");
        send(12'h0A5);
        chk("pd_din", {25'b0, datain}, 32'h25);
        chk("pd_therm", {15'b0, datatherm}, 32'h00001);
        en = 1'b0;
        for (int i = 0; i < PD; i++) begin
            tick();
            chk("pd_pdb_hi", {31'b0, pdb}, 1);
            chk("pd_zero", {8'b0, datain, datatherm}, 0);
        end
        tick();
        chk("pd_pdb_lo", {31'b0, pdb}, 0);

        // Async reset in the middle of power-up, away from any edge
        en = 1'b1;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_pdb", {31'b0, pdb}, 0);
        chk("arst_din", {25'b0, datainb}, 32'h7F);
        chk("arst_therm", {15'b0, datathermb}, 32'h1FFFF);
        chk("arst_fault", {31'b0, fault}, 0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            tick();
            if ($urandom_range(99) < 4) en = ~en;
            supply_ok = ($urandom_range(99) >= 2);
            code_valid = $urandom_range(1);
            if ($urandom_range(1) == 1) code = 12'($urandom);
            else code = {5'($urandom_range(17)), 7'($urandom)};
        end
        en = 1'b0; supply_ok = 1'b1; code_valid = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
